// File: rtl/rpm_pulse_counter.sv
// Hall-sensor pulse counter: sync + debounce front end, gated edge counting,
// and RPM conversion published with a one-cycle valid strobe.
module rpm_pulse_counter #(
  parameter int CNT_W           = 16,
  parameter int RPM_W           = 16,
  parameter int RPM_SCALE       = 60,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hall_in,
  input  logic             count_en,
  input  logic             done,
  output logic             pulse_seen,
  output logic [RPM_W-1:0] rpm,
  output logic             rpm_valid,
  output logic             overflow
);

  localparam int PROD_W = CNT_W + $clog2(RPM_SCALE + 1);
  localparam int EXT_W  = ((PROD_W > RPM_W) ? PROD_W : RPM_W) + 1;
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [EXT_W-1:0] RPM_MAX = {{(EXT_W - RPM_W){1'b0}}, {RPM_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, GATING, CALC, PUBLISH} state_t;

  logic            sync1;
  logic            hall_s;
  logic            hall_f;
  logic            hall_f_d;
  logic [DB_W-1:0] db_cnt;

  state_t          state_q;
  state_t          state_d;
  logic [CNT_W-1:0] count;
  logic            sat;
  logic [EXT_W-1:0] prod;
  logic            prod_sat;

  // Front end: hall_f only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= 1'b0;
      hall_s     <= 1'b0;
      hall_f     <= 1'b0;
      hall_f_d   <= 1'b0;
      db_cnt     <= '0;
      pulse_seen <= 1'b0;
    end else begin
      sync1      <= hall_in;
      hall_s     <= sync1;
      hall_f_d   <= hall_f;
      pulse_seen <= hall_f & ~hall_f_d;
      if (hall_s == hall_f) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        hall_f <= hall_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (count_en) state_d = GATING;
      GATING: begin
        if (count_en)  state_d = GATING;
        else if (done) state_d = CALC;
        else           state_d = IDLE;
      end
      CALC:    state_d = PUBLISH;
      PUBLISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign prod     = EXT_W'(count) * EXT_W'(RPM_SCALE);
  assign prod_sat = (prod > RPM_MAX);

  // rpm/overflow are loaded on the CALC->PUBLISH edge so they change together with rpm_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count     <= '0;
      sat       <= 1'b0;
      rpm       <= '0;
      rpm_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rpm_valid <= (state_q == CALC);
      case (state_q)
        IDLE: begin
          if (count_en) begin
            count <= CNT_W'(pulse_seen);
            sat   <= 1'b0;
          end
        end
        GATING: begin
          if (count_en && pulse_seen) begin
            if (count == CNT_MAX) sat <= 1'b1;
            else                  count <= count + 1'b1;
          end
        end
        CALC: begin
          rpm      <= prod_sat ? RPM_MAX[RPM_W-1:0] : prod[RPM_W-1:0];
          overflow <= sat | prod_sat;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rpm_pulse_counter.sv
// Bench for rpm_pulse_counter: three configurations driven in lockstep from one stimulus,
// checked by a table of windows, hand-written corner sequences and a random pulse-count model.
module tb_rpm_pulse_counter;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hall_in = 1'b0;
  logic count_en = 1'b0;
  logic done = 1'b0;

  logic        ps0, v0, o0;
  logic [15:0] rpm0;
  logic        ps1, v1, o1;
  logic [15:0] rpm1;
  logic        ps2, v2, o2;
  logic [7:0]  rpm2;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ps_total = 0;
  int valid_cnt = 0;
  logic v_prev = 1'b0;

  typedef struct {
    int n;
    int hi;
    int lo;
    int rpm_def; int ovf_def;
    int rpm_c4;  int ovf_c4;
    int rpm_r8;  int ovf_r8;
  } vec_t;

  vec_t vecs[8];

  rpm_pulse_counter d0 (
    .clk(clk), .rst(rst), .hall_in(hall_in), .count_en(count_en), .done(done),
    .pulse_seen(ps0), .rpm(rpm0), .rpm_valid(v0), .overflow(o0)
  );

  rpm_pulse_counter #(.CNT_W(4)) d1 (
    .clk(clk), .rst(rst), .hall_in(hall_in), .count_en(count_en), .done(done),
    .pulse_seen(ps1), .rpm(rpm1), .rpm_valid(v1), .overflow(o1)
  );

  rpm_pulse_counter #(.RPM_W(8)) d2 (
    .clk(clk), .rst(rst), .hall_in(hall_in), .count_en(count_en), .done(done),
    .pulse_seen(ps2), .rpm(rpm2), .rpm_valid(v2), .overflow(o2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (ps0) ps_total++;
    if (v0) begin
      valid_cnt++;
      chk("valid_not_back_to_back", int'(v_prev), 0);
    end
    v_prev = v0;
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic pulses(input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      hall_in = 1'b1;
      ticks(hi);
      hall_in = 1'b0;
      ticks(lo);
    end
  endtask

  // Issues done now and checks the publish timing and results of all three instances.
  task automatic finish_window(input int e0, input int f0, input int e1, input int f1,
                               input int e2, input int f2, input string tag);
    count_en = 1'b0;
    done = 1'b1;
    tick();
    done = 1'b0;
    chk({tag, "_valid_done+1"}, int'(v0), 0);
    tick();
    chk({tag, "_valid_done+2"}, int'(v0), 1);
    chk({tag, "_valid_c4"}, int'(v1), 1);
    chk({tag, "_valid_r8"}, int'(v2), 1);
    chk({tag, "_rpm_def"}, int'(rpm0), e0);
    chk({tag, "_ovf_def"}, int'(o0), f0);
    chk({tag, "_rpm_c4"}, int'(rpm1), e1);
    chk({tag, "_ovf_c4"}, int'(o1), f1);
    chk({tag, "_rpm_r8"}, int'(rpm2), e2);
    chk({tag, "_ovf_r8"}, int'(o2), f2);
    tick();
    chk({tag, "_valid_done+3"}, int'(v0), 0);
    ticks(3);
  endtask

  function automatic void ref_model(input int n, input int cnt_w, input int rpm_w,
                                    output int r, output int f);
    int cap, c, p, mx;
    cap = (1 << cnt_w) - 1;
    c = (n > cap) ? cap : n;
    p = c * 60;
    mx = (1 << rpm_w) - 1;
    r = (p > mx) ? mx : p;
    f = ((n > cap) || (p > mx)) ? 1 : 0;
  endfunction

  initial begin
    int first, base, vc, n, r0, f0, r1, f1, r2, f2;

    vecs[0] = '{25, 20, 20, 1500, 0, 900, 1, 255, 1};
    vecs[1] = '{20,  6,  6, 1200, 0, 900, 1, 255, 1};
    vecs[2] = '{10,  5,  7,  600, 0, 600, 0, 255, 1};
    vecs[3] = '{ 2,  8,  8,  120, 0, 120, 0, 120, 0};
    vecs[4] = '{ 0,  5,  5,    0, 0,   0, 0,   0, 0};
    vecs[5] = '{ 4,  4,  4,  240, 0, 240, 0, 240, 0};
    vecs[6] = '{15,  5,  5,  900, 0, 900, 0, 255, 1};
    vecs[7] = '{16,  5,  5,  960, 0, 900, 1, 255, 1};

    // Reset held with the Hall input toggling.
    tick();
    for (int i = 0; i < 3; i++) begin
      hall_in = ~hall_in;
      tick();
      chk("rst_rpm", int'(rpm0), 0);
      chk("rst_valid", int'(v0), 0);
      chk("rst_ovf", int'(o0), 0);
      chk("rst_pulse_seen", int'(ps0), 0);
    end
    hall_in = 1'b0;
    rst = 1'b0;
    tick();
    chk("post_rst_rpm", int'(rpm0), 0);
    chk("post_rst_valid", int'(v0), 0);
    chk("post_rst_ovf", int'(o0), 0);
    chk("post_rst_pulse_seen", int'(ps0), 0);
    ticks(10);

    // Glitch shorter than the debounce, then a 6-cycle pulse.
    base = ps_total;
    hall_in = 1'b1;
    ticks(3);
    hall_in = 1'b0;
    ticks(5);
    chk("glitch_no_pulse", ps_total - base, 0);
    hall_in = 1'b1;
    first = -1;
    for (int i = 1; i <= 14; i++) begin
      if (i == 7) hall_in = 1'b0;
      tick();
      if (ps0 && first < 0) first = i;
    end
    chk("pulse_latency_edge", first, 2 + D + 1);
    ticks(10);
    chk("pulse_count_one", ps_total - base, 1);

    // Table of clean windows.
    foreach (vecs[k]) begin
      vc = valid_cnt;
      count_en = 1'b1;
      ticks(3);
      pulses(vecs[k].n, vecs[k].hi, vecs[k].lo);
      ticks(10);
      chk($sformatf("vec%0d_no_early_valid", k), valid_cnt - vc, 0);
      finish_window(vecs[k].rpm_def, vecs[k].ovf_def, vecs[k].rpm_c4, vecs[k].ovf_c4,
                    vecs[k].rpm_r8, vecs[k].ovf_r8, $sformatf("vec%0d", k));
    end

    // Publish 1500, abort a window, then 2 pulses.
    count_en = 1'b1;
    ticks(3);
    pulses(25, 20, 20);
    ticks(10);
    finish_window(1500, 0, 900, 1, 255, 1, "pre_abort");
    vc = valid_cnt;
    count_en = 1'b1;
    ticks(2);
    pulses(1, 6, 6);
    ticks(8);
    count_en = 1'b0;
    ticks(8);
    chk("abort_no_valid", valid_cnt - vc, 0);
    chk("abort_rpm_held", int'(rpm0), 1500);
    count_en = 1'b1;
    ticks(3);
    pulses(2, 6, 6);
    ticks(10);
    finish_window(120, 0, 120, 0, 120, 0, "after_abort");

    // Reset in the middle of a window.
    count_en = 1'b1;
    ticks(3);
    pulses(7, 6, 6);
    rst = 1'b1;
    count_en = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_rpm_cleared", int'(rpm0), 0);
    chk("midrst_valid", int'(v0), 0);
    ticks(5);
    count_en = 1'b1;
    ticks(3);
    pulses(3, 6, 6);
    ticks(10);
    finish_window(180, 0, 180, 0, 180, 0, "after_midrst");

    // A pulse_seen landing in the done cycle must not be counted.
    count_en = 1'b1;
    ticks(3);
    pulses(2, 6, 6);
    ticks(6);
    hall_in = 1'b1;
    ticks(2 + D + 1);
    chk("done_cycle_strobe", int'(ps0), 1);
    finish_window(120, 0, 120, 0, 120, 0, "done_cycle_pulse");
    hall_in = 1'b0;
    ticks(10);

    // Random windows with sub-debounce glitches, against the arithmetic model.
    for (int w = 0; w < 20; w++) begin
      n = $urandom_range(0, 20);
      count_en = 1'b1;
      ticks(3);
      for (int p = 0; p < n; p++) begin
        if ($urandom_range(0, 1) == 1) begin
          hall_in = 1'b1;
          ticks($urandom_range(1, D - 1));
          hall_in = 1'b0;
          ticks($urandom_range(1, 4));
        end
        hall_in = 1'b1;
        ticks($urandom_range(D, 12));
        hall_in = 1'b0;
        ticks($urandom_range(D, 12));
      end
      ticks(10);
      ref_model(n, 16, 16, r0, f0);
      ref_model(n, 4, 16, r1, f1);
      ref_model(n, 16, 8, r2, f2);
      finish_window(r0, f0, r1, f1, r2, f2, $sformatf("rand%0d_n%0d", w, n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
